// File: rtl/vga_crossy_core.sv
// Crossy-road game core: 640x480@60 VGA timing, per-lane moving cars, player sprite,
// collision and saturating score. Video outputs are registered one cycle after the counters.

module vga_crossy_car #(
  parameter int IDX   = 1,
  parameter int CAR_W = 32
)(
  input  logic [9:0] i_x,
  input  logic [9:0] i_hcnt,
  output logic [9:0] o_nx,
  output logic       o_hit,
  output logic       o_px
);
  localparam logic [9:0] SPD = 10'((IDX % 4) + 1);

  function automatic logic [9:0] sub640(input logic [9:0] a, input logic [9:0] c);
    return (a >= c) ? a - c : a + 10'd640 - c;
  endfunction

  logic [9:0] w_up;

  // Even lanes drive right, odd lanes drive left; hit test uses the post-move position.
  always_comb begin
    w_up = i_x + SPD;
    if (IDX % 2 == 0) o_nx = (w_up >= 10'd640) ? w_up - 10'd640 : w_up;
    else              o_nx = sub640(i_x, SPD);
    o_hit = (sub640(10'd304, o_nx) < 10'(CAR_W)) || (sub640(o_nx, 10'd304) < 10'(CAR_W));
    o_px  = sub640(i_hcnt, i_x) < 10'(CAR_W);
  end
endmodule

module vga_crossy_core #(
  parameter int LANES   = 8,
  parameter int LANE_H  = 60,
  parameter int CAR_W   = 32,
  parameter int SCORE_W = 8
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_fwd,
  input  logic               btn_back,
  input  logic               pause,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [1:0]         r,
  output logic [1:0]         g,
  output logic [1:0]         b,
  output logic [SCORE_W-1:0] score,
  output logic               frame_tick
);
  localparam int          LW  = $clog2(LANES);
  localparam logic [LW-1:0] TOP = LW'(LANES-1);

  logic [9:0]               r_hcnt, r_vcnt;
  logic [2:0]               r_sf, r_sb;
  logic [1:0]               r_sp;
  logic                     r_pend_f, r_pend_b;
  logic [LW-1:0]            r_lane;
  logic [SCORE_W-1:0]       r_score;
  logic [LANES-2:1][9:0]    r_car_x;

  logic [LANES-2:1][9:0]    w_car_nx;
  logic [LANES-2:1]         w_car_hit, w_car_px;
  logic                     w_tick, w_hit;
  logic [LW-1:0]            w_lane_mv, w_lane_nx, w_lane_row;
  logic [SCORE_W-1:0]       w_score_nx;
  logic [9:0]               w_row, w_ry;
  logic                     w_vis, w_field, w_road, w_car_on, w_ply, w_car_vis;
  logic [5:0]               w_rgb;

  generate
    for (genvar i = 1; i < LANES-1; i++) begin : g_car
      vga_crossy_car #(.IDX(i), .CAR_W(CAR_W)) u_car (
        .i_x(r_car_x[i]), .i_hcnt(r_hcnt),
        .o_nx(w_car_nx[i]), .o_hit(w_car_hit[i]), .o_px(w_car_px[i])
      );
    end
  endgenerate

  assign w_tick = (r_hcnt == 10'd0) && (r_vcnt == 10'd480);
  assign score  = r_score;

  // Frame update: move, then cars, then collision (beats goal), then goal.
  always_comb begin
    w_lane_mv = r_lane;
    if (r_pend_f && !r_pend_b)                     w_lane_mv = r_lane + 1'b1;
    else if (r_pend_b && !r_pend_f && r_lane != '0) w_lane_mv = r_lane - 1'b1;
    w_hit = 1'b0;
    for (int i = 1; i < LANES-1; i++)
      if (w_lane_mv == LW'(i) && w_car_hit[i]) w_hit = 1'b1;
    w_lane_nx  = w_lane_mv;
    w_score_nx = r_score;
    if (w_hit) begin
      w_lane_nx  = '0;
      w_score_nx = '0;
    end else if (w_lane_mv == TOP) begin
      w_lane_nx = '0;
      if (r_score != '1) w_score_nx = r_score + 1'b1;
    end
  end

  // Lane 0 is drawn at the bottom of the field.
  always_comb begin
    w_row      = r_vcnt / 10'(LANE_H);
    w_ry       = r_vcnt % 10'(LANE_H);
    w_vis      = (r_hcnt < 10'd640) && (r_vcnt < 10'd480);
    w_field    = w_row < 10'(LANES);
    w_lane_row = TOP - LW'(w_row);
    w_road     = (w_lane_row != '0) && (w_lane_row != TOP);
    w_car_on   = 1'b0;
    for (int i = 1; i < LANES-1; i++)
      if (w_lane_row == LW'(i) && w_car_px[i]) w_car_on = 1'b1;
    w_ply      = (w_lane_row == r_lane) && (r_hcnt >= 10'd304) && (r_hcnt < 10'(304 + CAR_W)) &&
                 (w_ry >= 10'd4) && (w_ry < 10'(LANE_H - 4));
    w_car_vis  = w_road && w_car_on && (w_ry >= 10'd8) && (w_ry < 10'(LANE_H - 8));
    w_rgb      = 6'b00_00_00;
    if (w_vis && w_field) begin
      if (w_ply)          w_rgb = 6'b11_11_00;
      else if (w_car_vis) w_rgb = 6'b11_00_00;
      else if (w_road)    w_rgb = 6'b01_01_01;
      else                w_rgb = 6'b00_10_00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_sf       <= '0;
      r_sb       <= '0;
      r_sp       <= '0;
      r_pend_f   <= 1'b0;
      r_pend_b   <= 1'b0;
      r_lane     <= '0;
      r_score    <= '0;
      for (int i = 1; i < LANES-1; i++) r_car_x[i] <= 10'((i * 80) % 640);
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      de         <= 1'b0;
      {r, g, b}  <= '0;
      frame_tick <= 1'b0;
    end else begin
      if (r_hcnt == 10'd799) begin
        r_hcnt <= '0;
        r_vcnt <= (r_vcnt == 10'd524) ? 10'd0 : r_vcnt + 10'd1;
      end else begin
        r_hcnt <= r_hcnt + 10'd1;
      end
      r_sf <= {r_sf[1:0], btn_fwd};
      r_sb <= {r_sb[1:0], btn_back};
      r_sp <= {r_sp[0], pause};
      // Tick clears both flags even when paused, so a press never carries across frames.
      if (w_tick) begin
        r_pend_f <= 1'b0;
        r_pend_b <= 1'b0;
      end else begin
        if (r_sf[1] && !r_sf[2]) r_pend_f <= 1'b1;
        if (r_sb[1] && !r_sb[2]) r_pend_b <= 1'b1;
      end
      if (w_tick && !r_sp[1]) begin
        r_lane  <= w_lane_nx;
        r_score <= w_score_nx;
        r_car_x <= w_car_nx;
      end
      hsync      <= !((r_hcnt >= 10'd656) && (r_hcnt <= 10'd751));
      vsync      <= !((r_vcnt >= 10'd490) && (r_vcnt <= 10'd491));
      de         <= w_vis;
      {r, g, b}  <= w_rgb;
      frame_tick <= w_tick;
    end
  end
endmodule

// File: tb/tb_vga_crossy_core.sv
// Bench for vga_crossy_core: directed stimulus, frame results checked by a tick-driven scoreboard.
// Vertical counter is jumped ahead with force/release so whole frames fit a short run.

module tb_vga_crossy_core;
  localparam int LANES = 8, LANE_H = 60, CAR_W = 32, SCORE_W = 8;
  typedef logic [LANES-2:1][9:0] cars_t;

  logic clk = 1'b0, rst_n = 1'b0, btn_fwd = 1'b0, btn_back = 1'b0, pause = 1'b0;
  logic hsync, vsync, de, frame_tick;
  logic [1:0] r, g, b;
  logic [SCORE_W-1:0] score;

  int n_tests = 0, n_fail = 0;
  int m_lane = 0, m_score = 0;
  int m_car [1:LANES-2];
  int q_lane[$], q_score[$];
  cars_t q_cars[$];
  string q_nm[$];
  logic [9:0] f_v;
  cars_t f_cars;
  logic [SCORE_W-1:0] f_s;
  string mon_nm;
  int mon_l, mon_s;
  cars_t mon_c;

  always #20 clk = ~clk;

  vga_crossy_core #(.LANES(LANES), .LANE_H(LANE_H), .CAR_W(CAR_W), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .rst_n(rst_n), .btn_fwd(btn_fwd), .btn_back(btn_back), .pause(pause),
    .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b),
    .score(score), .frame_tick(frame_tick)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: each frame_tick pulse consumes one expected frame result.
  always @(negedge clk) begin
    if (rst_n && frame_tick) begin
      if (q_nm.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_tick: actual tick expected none");
      end else begin
        mon_nm = q_nm.pop_front();
        mon_l  = q_lane.pop_front();
        mon_s  = q_score.pop_front();
        mon_c  = q_cars.pop_front();
        chk({mon_nm, "_lane"}, int'(dut.r_lane), mon_l);
        chk({mon_nm, "_score"}, int'(score), mon_s);
        n_tests++;
        if (dut.r_car_x !== mon_c) begin
          n_fail++;
          $display("FAIL %s_cars: actual %h expected %h", mon_nm, dut.r_car_x, mon_c);
        end
      end
    end
  end

  function automatic cars_t pack_cars();
    cars_t v;
    for (int i = 1; i < LANES-1; i++) v[i] = 10'(m_car[i]);
    return v;
  endfunction

  task automatic force_cars();
    f_cars = pack_cars();
    @(negedge clk); force dut.r_car_x = f_cars;
    @(negedge clk); release dut.r_car_x;
  endtask

  task automatic jump_v(input int v);
    f_v = 10'(v);
    @(negedge clk); force dut.r_vcnt = f_v;
    @(negedge clk); release dut.r_vcnt;
  endtask

  task automatic press(input bit f, input bit bk);
    @(negedge clk); btn_fwd = f; btn_back = bk;
    repeat (3) @(negedge clk);
    btn_fwd = 1'b0; btn_back = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic model_tick(input bit pf, input bit pb, input bit paused);
    int c, s;
    bit hit;
    if (paused) return;
    if (pf && !pb) m_lane++;
    else if (pb && !pf && m_lane > 0) m_lane--;
    for (int i = 1; i < LANES-1; i++) begin
      s = (i % 4) + 1;
      m_car[i] = (i % 2 == 0) ? (m_car[i] + s) % 640 : (m_car[i] + 640 - s) % 640;
    end
    hit = 1'b0;
    if (m_lane >= 1 && m_lane <= LANES-2) begin
      c = m_car[m_lane];
      if (((304 - c + 640) % 640) < CAR_W || ((c - 304 + 640) % 640) < CAR_W) hit = 1'b1;
    end
    if (hit) begin
      m_lane = 0; m_score = 0;
    end else if (m_lane == LANES-1) begin
      m_lane = 0;
      if (m_score < (1 << SCORE_W) - 1) m_score++;
    end
  endtask

  task automatic next_tick();
    int t;
    jump_v(479);
    t = 0;
    while (!frame_tick && t < 2000) begin @(negedge clk); t++; end
    if (!frame_tick) begin
      n_tests++; n_fail++;
      $display("FAIL tick_timeout: actual no tick expected tick within 2000 clk");
      q_nm.delete(); q_lane.delete(); q_score.delete(); q_cars.delete();
    end else begin
      @(negedge clk);
      chk("tick_width", int'(frame_tick), 0);
    end
  endtask

  task automatic frame(input string nm, input int nf, input int nb);
    for (int k = 0; k < nf; k++) press(1'b1, 1'b0);
    for (int k = 0; k < nb; k++) press(1'b0, 1'b1);
    model_tick(nf > 0, nb > 0, pause);
    q_nm.push_back(nm); q_lane.push_back(m_lane); q_score.push_back(m_score);
    q_cars.push_back(pack_cars());
    next_tick();
  endtask

  task automatic probe(input string nm, input int vt, input int hp, input int exp);
    int t;
    jump_v(vt - 1);
    t = 0;
    while (de && t < 1000) begin @(negedge clk); t++; end
    while (!de && t < 2000) begin @(negedge clk); t++; end
    repeat (hp) @(negedge clk);
    chk(nm, int'({r, g, b}), exp);
  endtask

  initial begin
    int hl, dl, first_low, vl, tk, t;
    for (int i = 1; i < LANES-1; i++) m_car[i] = (i * 80) % 640;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_de", int'(de), 0);
    chk("rst_rgb", int'({r, g, b}), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_tick", int'(frame_tick), 0);
    rst_n = 1'b1;

    // Line 0 timing
    hl = 0; dl = 0; first_low = -1;
    for (int s = 0; s < 800; s++) begin
      @(negedge clk);
      if (!hsync) begin hl++; if (first_low < 0) first_low = s; end
      if (de) dl++;
    end
    chk("hsync_low_clks", hl, 96);
    chk("hsync_start", first_low, 656);
    chk("de_high_clks", dl, 640);

    // Vsync window
    jump_v(488);
    vl = 0; tk = 0;
    for (int s = 0; s < 4000; s++) begin
      @(negedge clk);
      if (!vsync) vl++;
      if (frame_tick) tk++;
    end
    chk("vsync_low_clks", vl, 1600);
    chk("no_tick_in_vblank_tail", tk, 0);

    // Rendering from reset positions
    probe("px_car_lane3", 4 * LANE_H + 30, 250, 6'b11_00_00);
    probe("px_road_lane3", 4 * LANE_H + 30, 300, 6'b01_01_01);
    probe("px_player_lane0", 7 * LANE_H + 30, 320, 6'b11_11_00);
    probe("px_safe_lane0", 7 * LANE_H + 30, 100, 6'b00_10_00);

    // Movement
    for (int i = 1; i < LANES-1; i++) m_car[i] = 600;
    force_cars();
    frame("fwd1", 1, 0);
    probe("px_player_lane1", 6 * LANE_H + 30, 320, 6'b11_11_00);
    probe("px_lane0_vacated", 7 * LANE_H + 30, 320, 6'b00_10_00);
    frame("fwd_twice", 2, 0);
    frame("fwd_and_back", 1, 1);
    frame("back1", 0, 1);
    frame("back_twice", 0, 2);
    frame("back_at_0", 0, 1);

    // Crossing to the top lane scores
    for (int i = 1; i < LANES-1; i++) m_car[i] = 600;
    force_cars();
    for (int k = 0; k < LANES-1; k++) frame($sformatf("goal_step%0d", k), 1, 0);

    // Pause freezes state while timing runs
    pause = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) frame($sformatf("paused%0d", k), 1, 0);
    jump_v(100);
    hl = 0;
    for (int s = 0; s < 800; s++) begin @(negedge clk); if (!hsync) hl++; end
    chk("paused_hsync_clks", hl, 96);
    pause = 1'b0;
    repeat (4) @(negedge clk);
    frame("after_pause", 0, 0);

    // Collision in lane 1
    m_car[1] = 306;
    force_cars();
    frame("collide", 1, 0);

    // Score saturation
    for (int i = 1; i < LANES-1; i++) m_car[i] = 600;
    force_cars();
    m_score = 255; f_s = 8'd255;
    @(negedge clk); force dut.r_score = f_s;
    @(negedge clk); release dut.r_score;
    for (int k = 0; k < LANES-1; k++) frame($sformatf("sat_step%0d", k), 1, 0);

    // Asynchronous reset mid-line, during the hsync pulse
    t = 0;
    while (hsync && t < 1000) begin @(negedge clk); t++; end
    chk("hsync_seen_before_reset", int'(hsync), 0);
    #5 rst_n = 1'b0;
    #1;
    chk("mid_rst_hsync", int'(hsync), 1);
    chk("mid_rst_vsync", int'(vsync), 1);
    chk("mid_rst_rgb", int'({r, g, b}), 0);
    chk("mid_rst_score", int'(score), 0);
    chk("mid_rst_de", int'(de), 0);
    repeat (2) @(negedge clk);
    chk("leftover_expect", q_nm.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(40 * 200000);
    $display("FAIL watchdog: actual still running expected finish");
    $fatal(1, "watchdog");
  end
endmodule
